// File: rtl/rom_fetch.sv
// -----------------------------------------------------------------------------
// rom_fetch
//
// Instruction fetch stage sitting between the Hack CPU and the SPRAM-backed
// instruction ROM.
//   * Holds the CPU off (valid=0) until the ROM reports its flash preload done.
//   * Streams sequential addresses to the ROM and absorbs the ROM's one-edge
//     read latency.
//   * Presents a registered instruction/pc pair with a valid flag.
//   * Supports CPU stalls through a one-deep skid register.
//   * Supports taken jumps with a single bubble.
//
// Parameters
//   ADDR_WIDTH   program counter width (Hack ROM: 15 bits, 32Ki words)
//   RESET_VECTOR first fetch address after the ROM becomes ready
//
// Ports
//   clk             in   system clock
//   reset           in   synchronous, active-high reset
//   clken           in   clock enable; all state frozen when low
//   rom_ready       in   ROM preload complete
//   rom_address     out  ROM read address (ADDR_WIDTH bits, zero-extended)
//   rom_instruction in   ROM read data for the address of the previous edge
//   stall           in   CPU cannot accept a new instruction this cycle
//   jump            in   CPU takes a jump; current output is consumed
//   jump_target     in   jump destination
//   instruction     out  fetched instruction (registered)
//   pc              out  address of instruction (registered)
//   valid           out  instruction/pc are meaningful
// -----------------------------------------------------------------------------
module rom_fetch #(
   parameter int ADDR_WIDTH   = 15,
   parameter int RESET_VECTOR = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic                  rom_ready,
   output logic [15:0]           rom_address,
   input  logic [15:0]           rom_instruction,
   input  logic                  stall,
   input  logic                  jump,
   input  logic [ADDR_WIDTH-1:0] jump_target,
   output logic [15:0]           instruction,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  valid
);

   localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(RESET_VECTOR);

   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   fetch_pc;
   logic [ADDR_WIDTH-1:0]   req_pc;
   logic                    inflight;

   logic [15:0]             skid_instr;
   logic [ADDR_WIDTH-1:0]   skid_pc;
   logic                    skid_valid;

   logic [ADDR_WIDTH-1:0]   addr_sel;

   // Program counter increment; wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
      return a + ADDR_WIDTH'(1);
   endfunction

   // Address presented to the ROM. While clken is low the ROM keeps re-reading
   // the in-flight address, so rom_instruction still carries req_pc's word when
   // the enable returns. A jump bypasses fetch_pc so the target word arrives on
   // the very next edge.
   always_comb begin
      addr_sel = fetch_pc;
      if (!clken) begin
         addr_sel = req_pc;
      end else if (state == ST_RUN && jump) begin
         addr_sel = jump_target;
      end
   end

   assign rom_address = 16'(addr_sel);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_WAIT;
         fetch_pc    <= START_PC;
         req_pc      <= START_PC;
         inflight    <= 1'b0;
         skid_valid  <= 1'b0;
         instruction <= '0;
         pc          <= '0;
         valid       <= 1'b0;
      end else if (clken) begin
         case (state)
            ST_WAIT: begin
               valid    <= 1'b0;
               inflight <= 1'b0;
               if (rom_ready) begin
                  state    <= ST_RUN;
                  fetch_pc <= START_PC;
               end
            end

            ST_RUN: begin
               if (!rom_ready) begin
                  // ROM went away (e.g. reload): drop everything in flight.
                  state      <= ST_WAIT;
                  valid      <= 1'b0;
                  inflight   <= 1'b0;
                  skid_valid <= 1'b0;
               end else if (jump) begin
                  // Jump wins over stall: the current output is consumed and the
                  // stale in-flight word is discarded, costing one bubble.
                  req_pc     <= jump_target;
                  fetch_pc   <= pc_inc(jump_target);
                  inflight   <= 1'b1;
                  skid_valid <= 1'b0;
                  valid      <= 1'b0;
               end else if (stall) begin
                  // Outputs hold. The word returning from the ROM this edge
                  // would be lost, so park it in the skid register.
                  if (inflight) begin
                     skid_instr <= rom_instruction;
                     skid_pc    <= req_pc;
                     skid_valid <= 1'b1;
                     inflight   <= 1'b0;
                  end
               end else begin
                  if (skid_valid) begin
                     instruction <= skid_instr;
                     pc          <= skid_pc;
                     valid       <= 1'b1;
                     if (inflight) begin
                        // Skid drained but another word is arriving: it takes
                        // the skid slot and no new fetch is issued this edge.
                        skid_instr <= rom_instruction;
                        skid_pc    <= req_pc;
                        inflight   <= 1'b0;
                     end else begin
                        skid_valid <= 1'b0;
                        req_pc     <= fetch_pc;
                        fetch_pc   <= pc_inc(fetch_pc);
                        inflight   <= 1'b1;
                     end
                  end else begin
                     if (inflight) begin
                        instruction <= rom_instruction;
                        pc          <= req_pc;
                        valid       <= 1'b1;
                     end else begin
                        valid <= 1'b0;
                     end
                     req_pc   <= fetch_pc;
                     fetch_pc <= pc_inc(fetch_pc);
                     inflight <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_fetch.sv
// -----------------------------------------------------------------------------
// tb_rom_fetch
//
// Table-driven bench for rom_fetch. A behavioural ROM returns
// ROM[n] = n ^ 16'hA5A5 one edge after the address is presented. Each table
// row holds the inputs for one clock and the outputs expected right after that
// clock edge. A short hand-written sequence then checks rom_address directly.
// -----------------------------------------------------------------------------
module tb_rom_fetch;

   localparam int AW = 15;

   logic          clk;
   logic          reset;
   logic          clken;
   logic          rom_ready;
   logic [15:0]   rom_address;
   logic [15:0]   rom_instruction;
   logic          stall;
   logic          jump;
   logic [AW-1:0] jump_target;
   logic [15:0]   instruction;
   logic [AW-1:0] pc;
   logic          valid;

   int total;
   int bad;

   typedef struct {
      logic          reset;
      logic          clken;
      logic          rom_ready;
      logic          stall;
      logic          jump;
      logic [AW-1:0] jt;
      logic          exp_valid;
      logic          chk;        // also compare pc/instruction
      logic [AW-1:0] exp_pc;
      logic [15:0]   exp_instr;
   } vec_t;

   vec_t vecs[$];

   rom_fetch #(
      .ADDR_WIDTH  (AW),
      .RESET_VECTOR(0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clken          (clken),
      .rom_ready      (rom_ready),
      .rom_address    (rom_address),
      .rom_instruction(rom_instruction),
      .stall          (stall),
      .jump           (jump),
      .jump_target    (jump_target),
      .instruction    (instruction),
      .pc             (pc),
      .valid          (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-edge-latency ROM model.
   always @(posedge clk) rom_instruction <= rom_address ^ 16'hA5A5;

   function automatic logic [15:0] rom_word(input logic [AW-1:0] a);
      return {1'b0, a} ^ 16'hA5A5;
   endfunction

   function automatic void add(input logic r, input logic ce, input logic rdy,
                               input logic st, input logic jp, input logic [AW-1:0] jt,
                               input logic ev, input logic chk, input logic [AW-1:0] epc);
      vec_t v;
      v.reset     = r;
      v.clken     = ce;
      v.rom_ready = rdy;
      v.stall     = st;
      v.jump      = jp;
      v.jt        = jt;
      v.exp_valid = ev;
      v.chk       = chk;
      v.exp_pc    = epc;
      v.exp_instr = ev ? rom_word(epc) : 16'h0000;
      vecs.push_back(v);
   endfunction

   // Streaming row: valid word at pc p.
   function automatic void run(input logic [AW-1:0] p);
      add(0, 1, 1, 0, 0, '0, 1, 1, p);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      reset       = 1'b1;
      clken       = 1'b1;
      rom_ready   = 1'b0;
      stall       = 1'b0;
      jump        = 1'b0;
      jump_target = '0;

      // ---------------- vector table ----------------
      add(1, 1, 0, 0, 0, '0, 0, 1, '0);
      add(1, 1, 0, 0, 0, '0, 0, 1, '0);
      for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, '0, 0, 1, '0);
      add(0, 1, 1, 0, 0, '0, 0, 1, '0);           // E0: enter RUN
      add(0, 1, 1, 0, 0, '0, 0, 1, '0);           // E1: first fetch issued
      for (int p = 0; p <= 5; p++) run(AW'(p));   // E2: pc 0 valid
      for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, '0, 1, 1, 15'd5); // stall
      for (int p = 6; p <= 9; p++) run(AW'(p));
      add(0, 1, 1, 0, 1, 15'h1234, 0, 0, '0);     // jump: bubble
      run(15'h1234);
      run(15'h1235);
      add(0, 1, 1, 1, 1, 15'h1234, 0, 0, '0);     // jump + stall: jump wins
      run(15'h1234);
      run(15'h1235);
      run(15'h1236);
      add(0, 0, 1, 0, 0, '0, 1, 1, 15'h1236);     // clken low: hold
      add(0, 0, 1, 0, 1, 15'h0100, 1, 1, 15'h1236); // jump ignored when clken low
      run(15'h1237);
      run(15'h1238);
      add(0, 0, 1, 1, 0, '0, 1, 1, 15'h1238);
      run(15'h1239);
      run(15'h123A);
      add(0, 1, 1, 1, 0, '0, 1, 1, 15'h123A);     // stall
      add(0, 0, 1, 0, 0, '0, 1, 1, 15'h123A);     // clken gap during stall
      run(15'h123B);                              // from skid
      add(0, 0, 1, 0, 0, '0, 1, 1, 15'h123B);     // gap right after issue edge
      run(15'h123C);
      run(15'h123D);
      add(0, 1, 1, 0, 1, 15'h7FFE, 0, 0, '0);     // jump near top
      run(15'h7FFE);
      run(15'h7FFF);
      run(15'h0000);                              // wrap
      run(15'h0001);
      add(1, 1, 1, 0, 0, '0, 0, 1, '0);           // reset mid-stream
      add(0, 1, 1, 0, 0, '0, 0, 1, '0);           // E0
      add(0, 1, 1, 0, 0, '0, 0, 1, '0);           // E1
      run(15'd0);
      run(15'd1);
      run(15'd2);
      add(0, 1, 0, 0, 0, '0, 0, 0, '0);           // rom_ready drop -> WAIT
      add(0, 1, 0, 0, 0, '0, 0, 0, '0);
      add(0, 1, 1, 0, 0, '0, 0, 0, '0);           // E0
      add(0, 1, 1, 0, 0, '0, 0, 0, '0);           // E1
      run(15'd0);
      run(15'd1);

      // ---------------- apply table ----------------
      foreach (vecs[i]) begin
         @(negedge clk);
         reset       = vecs[i].reset;
         clken       = vecs[i].clken;
         rom_ready   = vecs[i].rom_ready;
         stall       = vecs[i].stall;
         jump        = vecs[i].jump;
         jump_target = vecs[i].jt;
         @(posedge clk);
         #1;
         check($sformatf("row%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
         if (vecs[i].chk) begin
            check($sformatf("row%0d pc", i), 32'(pc), 32'(vecs[i].exp_pc));
            check($sformatf("row%0d instruction", i), 32'(instruction), 32'(vecs[i].exp_instr));
         end
      end

      // ---------------- hand sequence: ROM address selection ----------------
      // Stream is at pc=1 with address 2 in flight.
      @(negedge clk);
      jump        = 1'b1;
      jump_target = 15'h0555;
      stall       = 1'b0;
      clken       = 1'b1;
      #1;
      check("addr_on_jump", 32'(rom_address), 32'h0555);
      @(posedge clk);
      #1;
      check("jump_bubble_valid", 32'(valid), 32'd0);
      @(negedge clk);
      jump  = 1'b0;
      clken = 1'b0;
      #1;
      check("addr_clken_low", 32'(rom_address), 32'h0555);
      @(posedge clk);
      #1;
      check("clken_low_valid", 32'(valid), 32'd0);
      @(negedge clk);
      clken = 1'b1;
      #1;
      check("addr_next_fetch", 32'(rom_address), 32'h0556);
      @(posedge clk);
      #1;
      check("after_gap_valid", 32'(valid), 32'd1);
      check("after_gap_pc", 32'(pc), 32'h0555);
      check("after_gap_instr", 32'(instruction), 32'(rom_word(15'h0555)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
